// File: rtl/vram_wr_fifo_if.sv
//==============================================================================
// Module      : vram_wr_fifo_if
// Description : CPU write/read port and 16-bit VRAM toggle-handshake bus.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

interface vram_wr_fifo_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_a;
  logic [15:0] wr_d;
  logic        wr_u_n;
  logic        wr_l_n;
  logic        rd_req;
  logic [14:0] rd_a;
  logic        rd_busy;
  logic        rd_valid;
  logic [15:0] rd_q;
  logic        fifo_empty;
  logic        fifo_full;
  logic        vram_req;
  logic        vram_ack;
  logic        vram_we;
  logic        vram_u_n;
  logic        vram_l_n;
  logic [14:0] vram_a;
  logic [15:0] vram_d;
  logic [15:0] vram_q;

  modport slave (
    input  wr_valid, wr_a, wr_d, wr_u_n, wr_l_n, rd_req, rd_a, vram_ack, vram_q,
    output wr_ready, rd_busy, rd_valid, rd_q, fifo_empty, fifo_full,
           vram_req, vram_we, vram_u_n, vram_l_n, vram_a, vram_d
  );

  modport master (
    output wr_valid, wr_a, wr_d, wr_u_n, wr_l_n, rd_req, rd_a, vram_ack, vram_q,
    input  wr_ready, rd_busy, rd_valid, rd_q, fifo_empty, fifo_full,
           vram_req, vram_we, vram_u_n, vram_l_n, vram_a, vram_d
  );
endinterface

`default_nettype wire

// File: rtl/vram_wr_fifo.sv
//==============================================================================
// Module      : vram_wr_fifo
// Description : Write-buffering VRAM front end; reads wait for queued writes.
//               Optional sticky overflow flag when VRAM_FIFO_OVF_EN is defined.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module vram_wr_fifo #(
  parameter int DEPTH = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  vram_wr_fifo_if.slave      bus
`ifdef VRAM_FIFO_OVF_EN
  ,
  output      logic          ovf
`endif
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_pw = c_aw + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_pw-1:0]   r_wr_ptr;
  logic [c_pw-1:0]   r_rd_ptr;
  logic [32:0]       r_mem [DEPTH];
  logic [32:0]       w_head;
  logic              w_q_empty;
  logic              w_q_full;
  logic              w_push;
  logic              w_pop;
  logic              w_issue_rd;
  logic              w_rd_done;
  logic              w_acked;
  logic              r_req;
  logic              r_we;
  logic              r_u_n;
  logic              r_l_n;
  logic [14:0]       r_a;
  logic [15:0]       r_d;
  logic              r_rd_busy;
  logic              r_rd_valid;
  logic [15:0]       r_rd_q;
  logic [14:0]       r_rd_a;

  assign w_q_empty = (r_wr_ptr == r_rd_ptr);
  assign w_q_full  = (r_wr_ptr[c_pw-1] != r_rd_ptr[c_pw-1]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_push    = bus.wr_valid & ~w_q_full;
  assign w_head    = r_mem[r_rd_ptr[c_aw-1:0]];
  assign w_acked   = (bus.vram_ack == r_req);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= {bus.wr_a, bus.wr_d, bus.wr_u_n, bus.wr_l_n};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_pw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_pw'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Queued writes always win over a latched read so the read sees them.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue_rd  = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_q_empty) begin
          w_state_nxt = WR;
          w_pop       = 1'b1;
        end else if (r_rd_busy) begin
          w_state_nxt = RD;
          w_issue_rd  = 1'b1;
        end
      end
      WR: if (w_acked) w_state_nxt = IDLE;
      RD: begin
        if (w_acked) begin
          w_state_nxt = IDLE;
          w_rd_done   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= 1'b0;
      r_we  <= 1'b0;
      r_u_n <= 1'b1;
      r_l_n <= 1'b1;
      r_a   <= '0;
      r_d   <= '0;
    end else if (w_pop) begin
      r_req <= ~r_req;
      r_we  <= 1'b1;
      r_a   <= w_head[32:18];
      r_d   <= w_head[17:2];
      r_u_n <= w_head[1];
      r_l_n <= w_head[0];
    end else if (w_issue_rd) begin
      r_req <= ~r_req;
      r_we  <= 1'b0;
      r_a   <= r_rd_a;
      r_u_n <= 1'b0;
      r_l_n <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_busy  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_q     <= '0;
      r_rd_a     <= '0;
    end else begin
      r_rd_valid <= w_rd_done;
      if (w_rd_done) begin
        r_rd_q    <= bus.vram_q;
        r_rd_busy <= 1'b0;
      end else if (bus.rd_req && !r_rd_busy) begin
        r_rd_a    <= bus.rd_a;
        r_rd_busy <= 1'b1;
      end
    end
  end

`ifdef VRAM_FIFO_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ovf <= 1'b0;
    else if (bus.wr_valid && w_q_full) r_ovf <= 1'b1;
  end
  assign ovf = r_ovf;
`endif

  assign bus.wr_ready   = ~w_q_full;
  assign bus.fifo_full  = w_q_full;
  // A popped write stays "queued" until its ack returns.
  assign bus.fifo_empty = w_q_empty & (r_state != WR);
  assign bus.rd_busy    = r_rd_busy;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_q       = r_rd_q;
  assign bus.vram_req   = r_req;
  assign bus.vram_we    = r_we;
  assign bus.vram_u_n   = r_u_n;
  assign bus.vram_l_n   = r_l_n;
  assign bus.vram_a     = r_a;
  assign bus.vram_d     = r_d;

endmodule

`default_nettype wire

// File: tb/tb_vram_wr_fifo.sv
//==============================================================================
// Module      : tb_vram_wr_fifo
// Description : Directed self-checking bench with a behavioural VRAM responder.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_vram_wr_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vram_wr_fifo_if bif ();
`ifdef VRAM_FIFO_OVF_EN
  logic ovf;
  vram_wr_fifo #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave), .ovf(ovf));
`else
  vram_wr_fifo #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));
`endif

  typedef struct {
    bit          we;
    logic [14:0] a;
    logic [15:0] d;
  } acc_t;

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
    logic        u_n;
    logic        l_n;
    logic [15:0] exp_q;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int toggles = 0;
  int rv_count = 0;
  int ack_delay = 1;
  int cnt = 0;
  bit stall = 0;
  logic prev_req = 1'b0;
  logic [15:0] last_q = '0;
  logic [15:0] vmem [int];
  acc_t log_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // VRAM responder: acks after ack_delay cycles, applies byte enables.
  always @(posedge clk) begin
    logic [15:0] w;
    #1;
    if (!rst_n) begin
      bif.vram_ack = 1'b0;
      cnt = 0;
    end else begin
      if (bif.vram_req != prev_req) toggles++;
      if (bif.vram_req != bif.vram_ack && !stall) begin
        cnt++;
        if (cnt >= ack_delay) begin
          w = vmem.exists(int'(bif.vram_a)) ? vmem[int'(bif.vram_a)] : 16'h0000;
          if (bif.vram_we) begin
            if (!bif.vram_u_n) w[15:8] = bif.vram_d[15:8];
            if (!bif.vram_l_n) w[7:0]  = bif.vram_d[7:0];
            vmem[int'(bif.vram_a)] = w;
            log_q.push_back('{1'b1, bif.vram_a, bif.vram_d});
          end else begin
            bif.vram_q = w;
            log_q.push_back('{1'b0, bif.vram_a, w});
          end
          bif.vram_ack = bif.vram_req;
          cnt = 0;
        end
      end
      if (bif.rd_valid) begin
        rv_count++;
        last_q = bif.rd_q;
      end
    end
    prev_req = bif.vram_req;
  end

  task automatic do_write(input logic [14:0] a, input logic [15:0] d, input logic u, input logic l);
    bif.wr_valid = 1'b1; bif.wr_a = a; bif.wr_d = d; bif.wr_u_n = u; bif.wr_l_n = l;
    @(negedge clk);
    bif.wr_valid = 1'b0;
  endtask

  task automatic wait_rv(input int rv0, input string nm);
    int n = 0;
    while (rv_count == rv0 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      errors++; checks++;
      $display("FAIL %s: no rd_valid within 100 cycles", nm);
    end
  endtask

  task automatic do_read(input logic [14:0] a, input logic [15:0] exp, input string nm);
    int rv0 = rv_count;
    bif.rd_req = 1'b1; bif.rd_a = a;
    @(negedge clk);
    bif.rd_req = 1'b0;
    wait_rv(rv0, nm);
    check({nm, " rd_q"}, 32'(last_q), 32'(exp));
    check({nm, " rd_valid count"}, 32'(rv_count - rv0), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!(bif.fifo_empty && !bif.rd_busy && bif.vram_req == bif.vram_ack) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) begin
      errors++; checks++;
      $display("FAIL %s: not idle within 200 cycles", nm);
    end
  endtask

  initial begin
    vec_t vt[6];
    int t0, rv0;
    bif.wr_valid = 0; bif.wr_a = '0; bif.wr_d = '0; bif.wr_u_n = 1; bif.wr_l_n = 1;
    bif.rd_req = 0; bif.rd_a = '0; bif.vram_ack = 0; bif.vram_q = '0;

    // Write-then-read vectors; expected words folded by hand from the byte enables.
    vt[0] = '{15'h0010, 16'h1234, 1'b0, 1'b0, 16'h1234};
    vt[1] = '{15'h0010, 16'hABCD, 1'b0, 1'b1, 16'hAB34};
    vt[2] = '{15'h0010, 16'h5678, 1'b1, 1'b0, 16'hAB78};
    vt[3] = '{15'h0010, 16'hFFFF, 1'b1, 1'b1, 16'hAB78};
    vt[4] = '{15'h7FFF, 16'h8001, 1'b0, 1'b0, 16'h8001};
    vt[5] = '{15'h0020, 16'h00FF, 1'b0, 1'b1, 16'h0000};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst vram_req",   32'(bif.vram_req), 32'd0);
    check("rst vram_we",    32'(bif.vram_we), 32'd0);
    check("rst vram_u_n",   32'(bif.vram_u_n), 32'd1);
    check("rst vram_l_n",   32'(bif.vram_l_n), 32'd1);
    check("rst vram_a",     32'(bif.vram_a), 32'd0);
    check("rst vram_d",     32'(bif.vram_d), 32'd0);
    check("rst rd_busy",    32'(bif.rd_busy), 32'd0);
    check("rst rd_valid",   32'(bif.rd_valid), 32'd0);
    check("rst rd_q",       32'(bif.rd_q), 32'd0);
    check("rst fifo_empty", 32'(bif.fifo_empty), 32'd1);
    check("rst fifo_full",  32'(bif.fifo_full), 32'd0);
    check("rst wr_ready",   32'(bif.wr_ready), 32'd1);
`ifdef VRAM_FIFO_OVF_EN
    check("rst ovf", 32'(ovf), 32'd0);
`endif
    repeat (5) @(negedge clk);
    check("idle toggles", 32'(toggles), 32'd0);

    // Single write, ack after one cycle
    do_write(15'h0100, 16'hBEEF, 1'b0, 1'b0);
    check("w1 fifo_empty after push", 32'(bif.fifo_empty), 32'd0);
    @(negedge clk);
    check("w1 vram_req", 32'(bif.vram_req), 32'd1);
    check("w1 vram_we",  32'(bif.vram_we), 32'd1);
    check("w1 vram_a",   32'(bif.vram_a), 32'h0100);
    check("w1 vram_d",   32'(bif.vram_d), 32'hBEEF);
    check("w1 vram_be",  32'({bif.vram_u_n, bif.vram_l_n}), 32'd0);
    @(negedge clk);
    check("w1 fifo_empty after ack", 32'(bif.fifo_empty), 32'd1);
    check("w1 toggles", 32'(toggles), 32'd1);

    // Table-driven byte-enable vectors
    for (int i = 0; i < 6; i++) begin
      do_write(vt[i].a, vt[i].d, vt[i].u_n, vt[i].l_n);
      do_read(vt[i].a, vt[i].exp_q, $sformatf("vec%0d", i));
    end

    // Full FIFO: one write held in flight, then 5 more; 4 queue, 5th dropped
    wait_idle("pre-full");
    log_q.delete();
    stall = 1;
    do_write(15'h0500, 16'hCAFE, 1'b0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bif.wr_valid = 1'b1; bif.wr_a = 15'(15'h0400 + i); bif.wr_d = 16'(16'h1000 + i);
      bif.wr_u_n = 1'b0; bif.wr_l_n = 1'b0;
      if (i == 4) begin
        check("full fifo_full", 32'(bif.fifo_full), 32'd1);
        check("full wr_ready",  32'(bif.wr_ready), 32'd0);
      end
      @(negedge clk);
    end
    bif.wr_valid = 1'b0;
    check("full still full", 32'(bif.fifo_full), 32'd1);
`ifdef VRAM_FIFO_OVF_EN
    check("full ovf", 32'(ovf), 32'd1);
`endif
    stall = 0;
    wait_idle("drain");
    check("drain count", 32'(log_q.size()), 32'd5);
    if (log_q.size() == 5) begin
      check("drain0 a", 32'(log_q[0].a), 32'h0500);
      for (int i = 1; i < 5; i++) begin
        check($sformatf("drain%0d a", i), 32'(log_q[i].a), 32'(15'h0400 + i - 1));
        check($sformatf("drain%0d d", i), 32'(log_q[i].d), 32'(16'h1000 + i - 1));
      end
    end

    // Read right after a write waits for the write ack
    ack_delay = 3;
    log_q.delete();
    do_write(15'h0200, 16'h1234, 1'b0, 1'b0);
    do_read(15'h0200, 16'h1234, "raw");
    check("raw log size", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("raw first is write", 32'({log_q[0].we, log_q[0].a}), 32'({1'b1, 15'h0200}));
      check("raw second is read", 32'({log_q[1].we, log_q[1].a}), 32'({1'b0, 15'h0200}));
    end

    // Same-cycle write and read to one address
    rv0 = rv_count;
    bif.wr_valid = 1'b1; bif.wr_a = 15'h0300; bif.wr_d = 16'hA5A5; bif.wr_u_n = 0; bif.wr_l_n = 0;
    bif.rd_req = 1'b1; bif.rd_a = 15'h0300;
    @(negedge clk);
    bif.wr_valid = 1'b0; bif.rd_req = 1'b0;
    wait_rv(rv0, "same-cycle");
    check("same-cycle rd_q", 32'(last_q), 32'hA5A5);

    // Second rd_req while busy is ignored
    wait_idle("pre-busy");
    rv0 = rv_count;
    bif.rd_req = 1'b1; bif.rd_a = 15'h7FFF;
    @(negedge clk);
    bif.rd_req = 1'b0;
    check("busy rd_busy", 32'(bif.rd_busy), 32'd1);
    bif.rd_req = 1'b1; bif.rd_a = 15'h0010;
    @(negedge clk);
    bif.rd_req = 1'b0;
    wait_rv(rv0, "busy");
    repeat (12) @(negedge clk);
    check("busy rd_valid count", 32'(rv_count - rv0), 32'd1);
    check("busy rd_q", 32'(last_q), 32'h8001);

    // Reset while a write is pending
    wait_idle("pre-reset");
    ack_delay = 1;
    log_q.delete();
    stall = 1;
    do_write(15'h0600, 16'h7777, 1'b0, 1'b0);
    @(negedge clk);
    check("rst-mid pending", 32'(bif.vram_req != bif.vram_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst-mid vram_req", 32'(bif.vram_req), 32'd0);
    @(negedge clk);
    check("rst-mid fifo_empty", 32'(bif.fifo_empty), 32'd1);
    stall = 0;
    rst_n = 1'b1;
    t0 = toggles;
    repeat (10) @(negedge clk);
    check("rst-mid no toggles", 32'(toggles - t0), 32'd0);
    check("rst-mid vram_req after", 32'(bif.vram_req), 32'd0);
    check("rst-mid fifo_empty after", 32'(bif.fifo_empty), 32'd1);
    check("rst-mid no write", 32'(log_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

`default_nettype wire
